trace_packetizer: RTL

Downstream stage of the trace backpressure block. It accepts `{flag, payload}` trace words through a valid/ready handshake and buffers them in an internal synchronous FIFO. It frames each word as a sequence-numbered packet of narrow flits on the debug link. Flag = 1 marks a dropped-sample count word; flag = 0 marks a normal sample.

---
 rtl/trace_packetizer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/trace_packetizer.sv
// trace_packetizer: buffers {flag, payload} trace words in a small FIFO and
// frames each one as a packet of narrow flits: a header holding the flag and a
// sequence number, then the payload slices with the least significant slice first.
// Optional feature macro: TRACE_PKT_PARITY_EN appends an XOR parity flit to each packet.
module trace_packetizer #(
  parameter int unsigned sample_width_p    = 16,
  parameter int unsigned flit_width_p      = 8,
  parameter int unsigned fifo_addr_width_p = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [sample_width_p:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [flit_width_p-1:0]   flit_data,
  output logic                      flit_valid,
  input  logic                      flit_ready,
  output logic                      flit_last
);

  localparam int unsigned P     = (sample_width_p + flit_width_p - 1) / flit_width_p;
  localparam int unsigned PW    = P * flit_width_p;
  localparam int unsigned BW    = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned DEPTH = 1 << fifo_addr_width_p;
  localparam logic [BW-1:0]                LAST_BEAT = BW'(P - 1);
  localparam logic [fifo_addr_width_p:0]   FULL_CNT  = {1'b1, {fifo_addr_width_p{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PLD  = 2'd2
`ifdef TRACE_PKT_PARITY_EN
    , S_PAR = 2'd3
`endif
  } state_t;

  logic [sample_width_p:0]        r_mem [DEPTH];
  logic [fifo_addr_width_p-1:0]   r_wr_ptr;
  logic [fifo_addr_width_p-1:0]   r_rd_ptr;
  logic [fifo_addr_width_p:0]     r_count;
  state_t                         r_state;
  logic [sample_width_p:0]        r_hold;
  logic [BW-1:0]                  r_beat;
  logic [flit_width_p-2:0]        r_seq;

  state_t                         w_state_nxt;
  logic                           w_push;
  logic                           w_load;
  logic                           w_fifo_ne;
  logic                           w_beat_clr;
  logic                           w_beat_inc;
  logic                           w_seq_inc;
  logic [PW-1:0]                  w_pad;
  logic [flit_width_p-1:0]        w_slice;
  logic [flit_width_p-1:0]        w_header;
`ifdef TRACE_PKT_PARITY_EN
  logic [flit_width_p-1:0]        w_parity;
`endif

  // in_ready comes from the count register alone, so a full FIFO stays
  // closed for the cycle in which a pop happens and reopens on the next one.
  assign in_ready  = (r_count != FULL_CNT);
  assign w_push    = in_valid && in_ready;
  assign w_fifo_ne = (r_count != '0);
  assign w_header  = {r_hold[sample_width_p], r_seq};

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Holding register, beat counter and sequence number
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
      r_beat <= '0;
      r_seq  <= '0;
    end else begin
      if (w_load) r_hold <= r_mem[r_rd_ptr];
      if (w_beat_clr) begin
        r_beat <= '0;
      end else if (w_beat_inc) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_seq_inc) r_seq <= r_seq + 1'b1;
    end
  end

  // Payload slice selection (top slice zero-padded) and parity over the packet
  always_comb begin
    w_pad = '0;
    w_pad[sample_width_p-1:0] = r_hold[sample_width_p-1:0];
    w_slice = '0;
`ifdef TRACE_PKT_PARITY_EN
    w_parity = w_header;
`endif
    for (int unsigned i = 0; i < P; i++) begin
      if (r_beat == BW'(i)) w_slice = w_pad[i*flit_width_p +: flit_width_p];
`ifdef TRACE_PKT_PARITY_EN
      w_parity = w_parity ^ w_pad[i*flit_width_p +: flit_width_p];
`endif
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and flit outputs; end of packet reloads directly from the
  // FIFO so consecutive packets leave without a bubble
  always_comb begin
    w_state_nxt = r_state;
    flit_valid  = 1'b0;
    flit_last   = 1'b0;
    flit_data   = '0;
    w_load      = 1'b0;
    w_beat_clr  = 1'b0;
    w_beat_inc  = 1'b0;
    w_seq_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_ne) begin
          w_load      = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        flit_valid = 1'b1;
        flit_data  = w_header;
        if (flit_ready) begin
          w_beat_clr  = 1'b1;
          w_state_nxt = S_PLD;
        end
      end
      S_PLD: begin
        flit_valid = 1'b1;
        flit_data  = w_slice;
`ifndef TRACE_PKT_PARITY_EN
        flit_last  = (r_beat == LAST_BEAT);
`endif
        if (flit_ready) begin
          if (r_beat != LAST_BEAT) begin
            w_beat_inc = 1'b1;
          end else begin
`ifdef TRACE_PKT_PARITY_EN
            w_state_nxt = S_PAR;
`else
            w_seq_inc = 1'b1;
            if (w_fifo_ne) begin
              w_load      = 1'b1;
              w_state_nxt = S_HDR;
            end else begin
              w_state_nxt = S_IDLE;
            end
`endif
          end
        end
      end
`ifdef TRACE_PKT_PARITY_EN
      S_PAR: begin
        flit_valid = 1'b1;
        flit_last  = 1'b1;
        flit_data  = w_parity;
        if (flit_ready) begin
          w_seq_inc = 1'b1;
          if (w_fifo_ne) begin
            w_load      = 1'b1;
            w_state_nxt = S_HDR;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
